// File: rtl/v_report_mux_pkg.sv
// Shared constants for the N-channel virtual-peripheral reporter.
// FSM encodings, base chunk type and index-width helper.
package v_report_mux_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  localparam logic [7:0] CT_LED = 8'h02;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/v_report_mux_rr_arb.sv
// Round-robin arbiter: first request at/after the pointer, wrapping.
// Purely combinational; one-hot and index forms of the grant.
module v_report_mux_rr_arb
  import v_report_mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic          hi_vld;
  logic          lo_vld;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_vld = 1'b1;
        lo_idx = IW'(i);
        if (IW'(i) >= ptr_i) begin
          hi_vld = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
  end

  assign vld_o = lo_vld;
  assign idx_o = hi_vld ? hi_idx : lo_idx;

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = lo_vld && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/v_report_mux.sv
// N-channel change reporter: flags changed channels and presents
// one snapshot chunk at a time over a valid/ack handshake.
module v_report_mux
  import v_report_mux_pkg::*;
#(
  parameter int unsigned N_CHANNELS      = 4,
  parameter int unsigned CHUNK_TYPE_BASE = CT_LED,
  parameter int unsigned MIN_GAP_CYCLES  = 0,
  parameter int unsigned REPORT_AT_RESET = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [8*N_CHANNELS-1:0] values_i,
  input  logic                    refresh_i,
  output logic                    should_update_o,
  output logic [7:0]              tx_chunk_type_o,
  output logic [7:0]              tx_chunk_bytes_o,
  input  logic                    tx_ack_i,
  output logic [N_CHANNELS-1:0]   pending_o
);

  localparam int unsigned N  = N_CHANNELS;
  localparam int unsigned IW = idx_w(N);
  localparam logic [7:0] CT_BASE = CHUNK_TYPE_BASE[7:0];
  localparam logic [15:0] GAP_LD =
    (MIN_GAP_CYCLES > 0) ? 16'(MIN_GAP_CYCLES - 1) : 16'd0;
  localparam logic [N-1:0] PEND_RST =
    (REPORT_AT_RESET != 0) ? {N{1'b1}} : '0;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [15:0]    gap_q, gap_d;
  logic [8*N-1:0] last_q, last_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [7:0]     type_q, type_d;
  logic [7:0]     bytes_q, bytes_d;

  logic [N-1:0]  gnt;
  logic [IW-1:0] gidx;
  logic          gvld;
  logic          grant;
  logic [7:0]    sel;

  v_report_mux_rr_arb #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req_i (pend_q),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .vld_o (gvld)
  );

  assign grant = (state_q == ST_IDLE) && gvld;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    last_d  = last_q;
    type_d  = type_q;
    bytes_d = bytes_q;
    sel     = '0;
    pend_d  = pend_q | {N{refresh_i}};
    for (int i = 0; i < N; i++) begin
      if (values_i[8*i +: 8] != last_q[8*i +: 8]) pend_d[i] = 1'b1;
      if (gnt[i]) sel = values_i[8*i +: 8];
    end
    // Grant clears the channel, but a same-cycle refresh wins.
    if (grant) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          last_d[8*i +: 8] = sel;
          pend_d[i]        = refresh_i;
        end
      end
      bytes_d = sel;
      type_d  = CT_BASE + 8'(gidx);
      rr_d    = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (gvld) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (tx_ack_i) begin
          if (MIN_GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else gap_d = gap_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gap_q   <= '0;
      last_q  <= '0;
      pend_q  <= PEND_RST;
      type_q  <= CT_BASE;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      type_q  <= type_d;
      bytes_q <= bytes_d;
    end
  end

  assign should_update_o  = (state_q == ST_PRESENT);
  assign tx_chunk_type_o  = type_q;
  assign tx_chunk_bytes_o = bytes_q;
  assign pending_o        = pend_q;

endmodule
